// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with a RAW-hazard scoreboard for a pipeline without forwarding.
// Stalls IF/ID and injects EX bubbles until an in-flight producer has written back.
module id_ex_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned INFLIGHT = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [RA_W-1:0] id_rs1_addr_i,
    input  logic [RA_W-1:0] id_rs2_addr_i,
    input  logic            id_rs1_use_i,
    input  logic            id_rs2_use_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_op_b_sel_i,
    input  logic [3:0]      id_alu_op_i,
    input  logic [RA_W-1:0] id_rd_addr_i,
    input  logic            id_rd_wren_i,
    output logic            stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_op_a_o,
    output logic [XLEN-1:0] ex_op_b_o,
    output logic [4:0]      ex_shamt_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [3:0]      ex_alu_op_o,
    output logic [RA_W-1:0] ex_rd_addr_o,
    output logic            ex_rd_wren_o
);

    // Entry 0 tracks the instruction in EX; higher entries are MEM and WB.
    logic [INFLIGHT-1:0] sb_v_q, sb_v_d;
    logic [RA_W-1:0]     sb_rd_q [INFLIGHT];
    logic [RA_W-1:0]     sb_rd_d [INFLIGHT];

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_op_a_q, ex_op_a_d;
    logic [XLEN-1:0] ex_op_b_q, ex_op_b_d;
    logic [4:0]      ex_shamt_q, ex_shamt_d;
    logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [3:0]      ex_alu_op_q, ex_alu_op_d;
    logic [RA_W-1:0] ex_rd_addr_q, ex_rd_addr_d;
    logic            ex_rd_wren_q, ex_rd_wren_d;

    logic hit1, hit2, issue;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < INFLIGHT; k++) begin
            if (sb_v_q[k] && (sb_rd_q[k] == id_rs1_addr_i)) hit1 = 1'b1;
            if (sb_v_q[k] && (sb_rd_q[k] == id_rs2_addr_i)) hit2 = 1'b1;
        end
        hit1 = hit1 & id_rs1_use_i & (id_rs1_addr_i != '0);
        hit2 = hit2 & id_rs2_use_i & (id_rs2_addr_i != '0);
        stall_o = ~rst_i & id_valid_i & ~flush_i & (hit1 | hit2);
        issue   = id_valid_i & ~flush_i & ~stall_o;
    end

    always_comb begin
        sb_v_d[0]  = issue & id_rd_wren_i & (id_rd_addr_i != '0);
        sb_rd_d[0] = id_rd_addr_i;
        for (int k = 1; k < INFLIGHT; k++) begin
            sb_v_d[k]  = sb_v_q[k-1];
            sb_rd_d[k] = sb_rd_q[k-1];
        end
    end

    always_comb begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_op_a_d     = '0;
        ex_op_b_d     = '0;
        ex_shamt_d    = '0;
        ex_rs2_data_d = '0;
        ex_alu_op_d   = '0;
        ex_rd_addr_d  = '0;
        ex_rd_wren_d  = 1'b0;
        if (issue) begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = id_pc_i;
            ex_op_a_d     = id_rs1_data_i;
            ex_op_b_d     = id_op_b_sel_i ? id_imm_i : id_rs2_data_i;
            ex_shamt_d    = ex_op_b_d[4:0];
            ex_rs2_data_d = id_rs2_data_i;
            ex_alu_op_d   = id_alu_op_i;
            ex_rd_addr_d  = id_rd_addr_i;
            ex_rd_wren_d  = id_rd_wren_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_v_q        <= '0;
            for (int k = 0; k < INFLIGHT; k++) sb_rd_q[k] <= '0;
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_op_a_q     <= '0;
            ex_op_b_q     <= '0;
            ex_shamt_q    <= '0;
            ex_rs2_data_q <= '0;
            ex_alu_op_q   <= '0;
            ex_rd_addr_q  <= '0;
            ex_rd_wren_q  <= 1'b0;
        end else begin
            sb_v_q        <= sb_v_d;
            for (int k = 0; k < INFLIGHT; k++) sb_rd_q[k] <= sb_rd_d[k];
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_op_a_q     <= ex_op_a_d;
            ex_op_b_q     <= ex_op_b_d;
            ex_shamt_q    <= ex_shamt_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_alu_op_q   <= ex_alu_op_d;
            ex_rd_addr_q  <= ex_rd_addr_d;
            ex_rd_wren_q  <= ex_rd_wren_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_op_a_o     = ex_op_a_q;
    assign ex_op_b_o     = ex_op_b_q;
    assign ex_shamt_o    = ex_shamt_q;
    assign ex_rs2_data_o = ex_rs2_data_q;
    assign ex_alu_op_o   = ex_alu_op_q;
    assign ex_rd_addr_o  = ex_rd_addr_q;
    assign ex_rd_wren_o  = ex_rd_wren_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios followed by random traffic,
// checked against a model that tracks the issue cycle of each register's latest writer.
module tb_id_ex_stage;
    localparam int INFLIGHT = 3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        bsel;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wren;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] rs2d;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wren;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_use = 1'b0;
    logic        rs2_use = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic        op_b_sel = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [4:0]  rd_addr = '0;
    logic        rd_wren = 1'b0;

    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_rs2_data;
    logic [4:0]  ex_shamt;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_wren;

    int checks = 0;
    int errors = 0;
    ex_t exp_q[$];
    int  last_wr[32];
    int  cyc = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .id_valid_i    (id_valid),
        .id_pc_i       (id_pc),
        .id_rs1_addr_i (rs1_addr),
        .id_rs2_addr_i (rs2_addr),
        .id_rs1_use_i  (rs1_use),
        .id_rs2_use_i  (rs2_use),
        .id_rs1_data_i (rs1_data),
        .id_rs2_data_i (rs2_data),
        .id_imm_i      (imm),
        .id_op_b_sel_i (op_b_sel),
        .id_alu_op_i   (alu_op),
        .id_rd_addr_i  (rd_addr),
        .id_rd_wren_i  (rd_wren),
        .stall_o       (stall),
        .ex_valid_o    (ex_valid),
        .ex_pc_o       (ex_pc),
        .ex_op_a_o     (ex_op_a),
        .ex_op_b_o     (ex_op_b),
        .ex_shamt_o    (ex_shamt),
        .ex_rs2_data_o (ex_rs2_data),
        .ex_alu_op_o   (ex_alu_op),
        .ex_rd_addr_o  (ex_rd_addr),
        .ex_rd_wren_o  (ex_rd_wren)
    );

    function automatic logic busy(input logic [4:0] r);
        return (r != 0) && ((cyc - last_wr[r]) <= INFLIGHT);
    endfunction

    function automatic instr_t mk(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                                  input logic u2, input logic [4:0] rd, input logic w);
        instr_t i;
        i.valid = 1'b1;
        i.pc    = $urandom & 32'hFFFF_FFFC;
        i.rs1   = r1;
        i.rs2   = r2;
        i.use1  = u1;
        i.use2  = u2;
        i.d1    = $urandom;
        i.d2    = $urandom;
        i.imm   = $urandom;
        i.bsel  = 1'($urandom_range(0, 1));
        i.op    = 4'($urandom_range(0, 15));
        i.rd    = rd;
        i.wren  = w;
        return i;
    endfunction

    // One clock cycle: drive ID, check stall against the model, queue the expected EX state.
    task automatic step(input instr_t ins, input logic fl, input logic rs, output logic st);
        logic exp_st, iss;
        ex_t  e;
        @(posedge clk);
        #1;
        rst = rs; flush = fl; id_valid = ins.valid; id_pc = ins.pc;
        rs1_addr = ins.rs1; rs2_addr = ins.rs2; rs1_use = ins.use1; rs2_use = ins.use2;
        rs1_data = ins.d1; rs2_data = ins.d2; imm = ins.imm; op_b_sel = ins.bsel;
        alu_op = ins.op; rd_addr = ins.rd; rd_wren = ins.wren;
        @(negedge clk);
        exp_st = !rs && ins.valid && !fl &&
                 ((ins.use1 && busy(ins.rs1)) || (ins.use2 && busy(ins.rs2)));
        checks++;
        if (stall !== exp_st) begin
            errors++;
            $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, exp_st);
        end
        iss = !rs && ins.valid && !fl && !exp_st;
        e = '0;
        if (iss) begin
            e.valid = 1'b1;
            e.pc    = ins.pc;
            e.a     = ins.d1;
            e.b     = ins.bsel ? ins.imm : ins.d2;
            e.shamt = 5'(e.b % 32);
            e.rs2d  = ins.d2;
            e.op    = ins.op;
            e.rd    = ins.rd;
            e.wren  = ins.wren;
        end
        exp_q.push_back(e);
        if (rs) begin
            for (int r = 0; r < 32; r++) last_wr[r] = -100;
        end else if (iss && ins.wren && ins.rd != 0) begin
            last_wr[ins.rd] = cyc;
        end
        cyc++;
        st = exp_st;
    endtask

    task automatic idle(input int n);
        logic st;
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, st);
    endtask

    task automatic issue_one(input instr_t ins, input int exp_stalls, input string name);
        logic st;
        int   n = 0;
        do begin
            step(ins, 1'b0, 1'b0, st);
            if (st) n++;
        end while (st && n <= 8);
        checks++;
        if (n != exp_stalls) begin
            errors++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, n, exp_stalls);
        end
    endtask

    // Monitor: EX outputs are sampled just after each edge and compared in order.
    initial begin
        ex_t e, got;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {ex_valid, ex_pc, ex_op_a, ex_op_b, ex_shamt, ex_rs2_data, ex_alu_op,
                       ex_rd_addr, ex_rd_wren};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL ex_regs t=%0t got v=%b pc=%h a=%h b=%h sh=%0d s=%h op=%h rd=%0d w=%b exp v=%b pc=%h a=%h b=%h sh=%0d s=%h op=%h rd=%0d w=%b",
                             $time, got.valid, got.pc, got.a, got.b, got.shamt, got.rs2d, got.op,
                             got.rd, got.wren, e.valid, e.pc, e.a, e.b, e.shamt, e.rs2d, e.op,
                             e.rd, e.wren);
                end
            end
        end
    end

    initial begin
        instr_t c, cur;
        logic   st, fl, rs, have;
        for (int r = 0; r < 32; r++) last_wr[r] = -100;

        // Reset cycles: stall forced low, EX cleared.
        step(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1, st);
        step(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1, st);

        // Independent back-to-back writers.
        issue_one(mk(0, 1, 0, 0, 1, 1), 0, "indep1");
        issue_one(mk(0, 1, 0, 0, 2, 1), 0, "indep2");
        issue_one(mk(0, 1, 0, 0, 3, 1), 0, "indep3");
        idle(4);

        // Producer x5, consumer at distance 1..4.
        for (int d = 1; d <= 4; d++) begin
            issue_one(mk(0, 0, 0, 0, 5, 1), 0, "producer");
            for (int f = 1; f < d; f++) issue_one(mk(0, 0, 0, 0, 0, 0), 0, "filler");
            issue_one(mk(5, 1, 0, 0, 10, 1), 4 - d, "raw_dist");
            idle(4);
        end

        // x0 never tracked; unused rs2 never stalls.
        issue_one(mk(0, 0, 0, 0, 0, 1), 0, "wr_x0");
        issue_one(mk(0, 1, 0, 1, 11, 1), 0, "rd_x0");
        issue_one(mk(0, 0, 0, 0, 6, 1), 0, "wr_x6");
        issue_one(mk(1, 1, 6, 0, 12, 1), 0, "rs2_unused");
        idle(4);

        // Immediate operand B with upper bits retained, shift amount 31.
        c = mk(1, 1, 2, 0, 13, 1);
        c.bsel = 1'b1;
        c.imm  = 32'h0000_041F;
        c.op   = 4'hD;
        issue_one(c, 0, "sra_imm");
        idle(4);

        // Flush during the second stall cycle.
        issue_one(mk(0, 0, 0, 0, 7, 1), 0, "wr_x7");
        c = mk(7, 1, 0, 0, 14, 1);
        step(c, 1'b0, 1'b0, st);
        step(c, 1'b1, 1'b0, st);
        issue_one(mk(1, 1, 2, 1, 15, 1), 0, "after_flush");
        idle(4);

        // Reset during a stall drops the pending hazard.
        issue_one(mk(0, 0, 0, 0, 9, 1), 0, "wr_x9");
        c = mk(9, 1, 0, 0, 16, 1);
        step(c, 1'b0, 1'b0, st);
        step(c, 1'b0, 1'b1, st);
        issue_one(c, 0, "after_reset");
        idle(4);

        // Random traffic over a small register set to provoke hazards.
        have = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!have) begin
                cur = mk(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                cur.valid = ($urandom_range(0, 7) != 0);
                have = 1'b1;
            end
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 99) == 0);
            step(cur, fl, rs, st);
            if (!st) have = 1'b0;
        end
        idle(2);
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
